// File: rtl/sobel_edge_pipeline.sv
// sobel_edge_pipeline: 3-stage Sobel gradient magnitude over a 3x3 window of 4-bit pixels,
// with border suppression, thresholding and per-frame edge counting.
module sobel_edge_pipeline #(
    parameter int THRESHOLD = 32,
    parameter int X_MAX     = 319,
    parameter int Y_MAX     = 239
) (
    input  logic                  mainClk,
    input  logic                  reset,
    input  logic [2:0][2:0][3:0]  pixelData,
    input  logic                  pixelDataValid,
    input  logic [9:0]            spiXVal,
    input  logic [8:0]            spiYVal,
    output logic                  edgeValid,
    output logic [3:0]            edgeMag,
    output logic                  edgeBit,
    output logic [9:0]            edgeX,
    output logic [8:0]            edgeY,
    output logic                  frameDone,
    output logic [16:0]           frameEdgeCount
);

    function automatic logic [6:0] weightedSum(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic [3:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [6:0] absVal(input logic [6:0] v);
        return v[6] ? (~v + 7'd1) : v;
    endfunction

    // Differences of two 0..60 sums wrap into 7-bit two's complement (-60..+60).
    logic [6:0] gxNext;
    logic [6:0] gyNext;
    assign gxNext = weightedSum(pixelData[0][2], pixelData[1][2], pixelData[2][2])
                  - weightedSum(pixelData[0][0], pixelData[1][0], pixelData[2][0]);
    assign gyNext = weightedSum(pixelData[2][0], pixelData[2][1], pixelData[2][2])
                  - weightedSum(pixelData[0][0], pixelData[0][1], pixelData[0][2]);

    // The Sobel kernels give the centre pixel zero weight.
    logic unusedCenter;
    assign unusedCenter = ^pixelData[1][1];

    logic        s1Valid;
    logic [6:0]  s1Gx;
    logic [6:0]  s1Gy;
    logic [9:0]  s1X;
    logic [8:0]  s1Y;
    logic        s2Valid;
    logic [6:0]  s2Mag;
    logic [9:0]  s2X;
    logic [8:0]  s2Y;
    logic [16:0] runCount;

    logic        isBorder;
    logic        isLast;
    logic [3:0]  magOut;
    logic        bitOut;

    always_comb begin
        isBorder = 1'b0;
        isLast   = 1'b0;
        magOut   = 4'd0;
        bitOut   = 1'b0;
        isBorder = (s2X < 10'd2);
        isLast   = (s2X == 10'(X_MAX)) && (s2Y == 9'(Y_MAX));
        if (!isBorder) begin
            magOut = s2Mag[6:3];
            bitOut = (s2Mag >= 7'(THRESHOLD));
        end
    end

    always_ff @(posedge mainClk) begin
        if (reset) begin
            s1Valid        <= 1'b0;
            s2Valid        <= 1'b0;
            edgeValid      <= 1'b0;
            edgeMag        <= 4'd0;
            edgeBit        <= 1'b0;
            edgeX          <= 10'd0;
            edgeY          <= 9'd0;
            frameDone      <= 1'b0;
            runCount       <= 17'd0;
            frameEdgeCount <= 17'd0;
        end else begin
            s1Valid   <= pixelDataValid;
            s2Valid   <= s1Valid;
            edgeValid <= s2Valid;
            frameDone <= s2Valid && isLast;
            if (s2Valid) begin
                edgeMag <= magOut;
                edgeBit <= bitOut;
                edgeX   <= s2X;
                edgeY   <= s2Y;
                // Last pixel of the frame: publish the total and restart the count.
                if (isLast) begin
                    frameEdgeCount <= runCount + {16'd0, bitOut};
                    runCount       <= 17'd0;
                end else begin
                    runCount <= runCount + {16'd0, bitOut};
                end
            end
        end
    end

    // Datapath registers are qualified by the valid bits, so they need no reset.
    always_ff @(posedge mainClk) begin
        s1Gx  <= gxNext;
        s1Gy  <= gyNext;
        s1X   <= spiXVal;
        s1Y   <= spiYVal;
        s2Mag <= absVal(s1Gx) + absVal(s1Gy);
        s2X   <= s1X;
        s2Y   <= s1Y;
    end

endmodule

// File: tb/tb_sobel_edge_pipeline.sv
// Bench for sobel_edge_pipeline: table vectors, random windows against a convolution
// reference model with a timestamped scoreboard, frame accounting and reset sequences.
module tb_sobel_edge_pipeline;
    localparam int THRESHOLD = 32;
    localparam int X_MAX     = 319;
    localparam int Y_MAX     = 239;

    typedef logic [2:0][2:0][3:0] win_t;

    logic        mainClk = 1'b0;
    logic        reset;
    win_t        pixelData;
    logic        pixelDataValid;
    logic [9:0]  spiXVal;
    logic [8:0]  spiYVal;
    logic        edgeValid;
    logic [3:0]  edgeMag;
    logic        edgeBit;
    logic [9:0]  edgeX;
    logic [8:0]  edgeY;
    logic        frameDone;
    logic [16:0] frameEdgeCount;

    always #5 mainClk = ~mainClk;

    sobel_edge_pipeline #(.THRESHOLD(THRESHOLD), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .mainClk(mainClk), .reset(reset), .pixelData(pixelData),
        .pixelDataValid(pixelDataValid), .spiXVal(spiXVal), .spiYVal(spiYVal),
        .edgeValid(edgeValid), .edgeMag(edgeMag), .edgeBit(edgeBit),
        .edgeX(edgeX), .edgeY(edgeY), .frameDone(frameDone),
        .frameEdgeCount(frameEdgeCount)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic win_t win9(input int a, input int b, input int c,
                                  input int d, input int e, input int f,
                                  input int g, input int h, input int i);
        win_t w;
        w[0][0] = 4'(a); w[0][1] = 4'(b); w[0][2] = 4'(c);
        w[1][0] = 4'(d); w[1][1] = 4'(e); w[1][2] = 4'(f);
        w[2][0] = 4'(g); w[2][1] = 4'(h); w[2][2] = 4'(i);
        return w;
    endfunction

    // Reference: direct 3x3 convolution with the Sobel kernels, L1 magnitude.
    function automatic int refMag(input win_t w);
        int gx = 0;
        int gy = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int wr = (r == 1) ? 2 : 1;
                int wc = (c == 1) ? 2 : 1;
                gx += (c - 1) * wr * int'(w[r][c]);
                gy += (r - 1) * wc * int'(w[r][c]);
            end
        end
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    typedef struct { int due; int mag; int edgeB; int x; int y; } exp_t;
    exp_t pending[$];
    int   cyc = 0;
    int   runCnt = 0;
    int   expFrame = 0;
    int   frameDonesSeen = 0;
    logic monitorOn = 1'b0;

    // Model: timestamp each accepted window with the cycle its result must appear.
    initial begin
        exp_t e;
        int   m;
        forever begin
            @(posedge mainClk);
            cyc++;
            if (reset) begin
                pending.delete();
                runCnt   = 0;
                expFrame = 0;
            end else if (pixelDataValid) begin
                m       = refMag(pixelData);
                e.due   = cyc + 2;
                e.x     = int'(spiXVal);
                e.y     = int'(spiYVal);
                e.mag   = (spiXVal < 2) ? 0 : m / 8;
                e.edgeB = (spiXVal >= 2 && m >= THRESHOLD) ? 1 : 0;
                pending.push_back(e);
            end
        end
    end

    // Scoreboard: compare each cycle between clock edges.
    initial begin
        exp_t e;
        logic expValid;
        logic last;
        forever begin
            @(negedge mainClk);
            if (monitorOn) begin
                while (pending.size() > 0 && pending[0].due < cyc) begin
                    e = pending.pop_front();
                    check("missed output", 32'(0), 32'(1));
                end
                expValid = (pending.size() > 0 && pending[0].due == cyc);
                check("edgeValid", 32'(edgeValid), 32'(expValid));
                last = 1'b0;
                if (expValid && edgeValid) begin
                    e = pending.pop_front();
                    check("edgeMag", 32'(edgeMag), 32'(e.mag));
                    check("edgeBit", 32'(edgeBit), 32'(e.edgeB));
                    check("edgeX", 32'(edgeX), 32'(e.x));
                    check("edgeY", 32'(edgeY), 32'(e.y));
                    last = (e.x == X_MAX && e.y == Y_MAX);
                    if (last) begin
                        expFrame = runCnt + e.edgeB;
                        runCnt   = 0;
                    end else begin
                        runCnt += e.edgeB;
                    end
                end else if (expValid) begin
                    e = pending.pop_front();
                end
                check("frameDone", 32'(frameDone), 32'(last));
                check("frameEdgeCount", 32'(frameEdgeCount), 32'(expFrame));
                if (frameDone) frameDonesSeen++;
            end
        end
    end

    task automatic putWin(input win_t w, input int x, input int y);
        pixelData      = w;
        spiXVal        = 10'(x);
        spiYVal        = 9'(y);
        pixelDataValid = 1'b1;
        @(negedge mainClk);
    endtask

    task automatic idle(input int n);
        pixelDataValid = 1'b0;
        repeat (n) @(negedge mainClk);
    endtask

    task automatic pulseReset();
        pixelDataValid = 1'b0;
        reset = 1'b1;
        @(negedge mainClk);
        reset = 1'b0;
    endtask

    typedef struct { string name; win_t win; int x; int y; int mag; int edgeB; } vec_t;
    vec_t vecs[8];

    initial begin
        win_t uniform9, vert, diag, horiz, ramp32, ramp30;
        logic obsValid [8];
        int   obsX [8];
        int   cnt;

        uniform9 = win9(9, 9, 9, 9, 9, 9, 9, 9, 9);
        vert     = win9(0, 8, 15, 0, 8, 15, 0, 8, 15);
        diag     = win9(15, 15, 0, 15, 0, 0, 0, 0, 0);
        horiz    = win9(0, 0, 0, 5, 5, 5, 15, 15, 15);
        ramp32   = win9(0, 0, 8, 0, 0, 8, 0, 0, 8);
        ramp30   = win9(0, 0, 8, 0, 0, 7, 0, 0, 8);

        vecs[0] = '{"uniform",      uniform9, 5,  0, 0,  0};
        vecs[1] = '{"vertical",     vert,     10, 1, 7,  1};
        vecs[2] = '{"diagonal",     diag,     20, 2, 11, 1};
        vecs[3] = '{"diag border",  diag,     1,  2, 0,  0};
        vecs[4] = '{"horizontal",   horiz,    40, 7, 7,  1};
        vecs[5] = '{"mag 32",       ramp32,   50, 8, 4,  1};
        vecs[6] = '{"mag 30",       ramp30,   51, 8, 3,  0};
        vecs[7] = '{"vert x=2",     vert,     2,  9, 7,  1};

        reset = 1'b1;
        pixelDataValid = 1'b0;
        pixelData = '0;
        spiXVal = '0;
        spiYVal = '0;
        repeat (3) @(negedge mainClk);
        check("rst edgeValid", 32'(edgeValid), 32'(0));
        check("rst edgeMag", 32'(edgeMag), 32'(0));
        check("rst edgeBit", 32'(edgeBit), 32'(0));
        check("rst edgeX", 32'(edgeX), 32'(0));
        check("rst edgeY", 32'(edgeY), 32'(0));
        check("rst frameDone", 32'(frameDone), 32'(0));
        check("rst frameEdgeCount", 32'(frameEdgeCount), 32'(0));
        reset = 1'b0;
        monitorOn = 1'b1;

        for (int v = 0; v < 8; v++) begin
            putWin(vecs[v].win, vecs[v].x, vecs[v].y);
            idle(2);
            check({"vec valid ", vecs[v].name}, 32'(edgeValid), 32'(1));
            check({"vec mag ", vecs[v].name}, 32'(edgeMag), 32'(vecs[v].mag));
            check({"vec bit ", vecs[v].name}, 32'(edgeBit), 32'(vecs[v].edgeB));
            check({"vec x ", vecs[v].name}, 32'(edgeX), 32'(vecs[v].x));
            idle(1);
        end

        // Four back-to-back windows: outputs at cycles 3..6 after the first, in order.
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                pixelData = vert;
                spiXVal = 10'(30 + c);
                spiYVal = 9'd3;
                pixelDataValid = 1'b1;
            end else begin
                pixelDataValid = 1'b0;
            end
            @(negedge mainClk);
            obsValid[c] = edgeValid;
            obsX[c] = int'(edgeX);
        end
        for (int c = 0; c < 8; c++) begin
            if (c >= 2 && c <= 5) begin
                check("b2b valid", 32'(obsValid[c]), 32'(1));
                check("b2b order x", 32'(obsX[c]), 32'(30 + c - 2));
            end else begin
                check("b2b idle", 32'(obsValid[c]), 32'(0));
            end
        end
        idle(4);

        // Random windows, occasionally landing on the frame's last coordinate.
        for (int n = 0; n < 400; n++) begin
            win_t w;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] = 4'($urandom_range(0, 15));
            pixelData = w;
            if ($urandom_range(0, 15) == 0) begin
                spiXVal = 10'(X_MAX);
                spiYVal = 9'(Y_MAX);
            end else begin
                spiXVal = 10'($urandom_range(0, X_MAX));
                spiYVal = 9'($urandom_range(0, Y_MAX));
            end
            pixelDataValid = ($urandom_range(0, 3) != 0);
            @(negedge mainClk);
        end
        idle(5);

        // Frame: 99 counted edges + edge on the last pixel = 100; border edges excluded.
        pulseReset();
        frameDonesSeen = 0;
        for (int i = 0; i < 198; i++) begin
            if (i % 2 == 0) putWin(vert, 2 + i, i / 64);
            else            putWin(uniform9, 2 + i, i / 64);
        end
        putWin(vert, 1, Y_MAX);
        putWin(vert, 0, Y_MAX);
        putWin(vert, X_MAX, Y_MAX);
        idle(4);
        check("frame1 count", 32'(frameEdgeCount), 32'(100));
        check("frame1 doneCount", 32'(frameDonesSeen), 32'(1));

        putWin(vert, 5, 0);
        putWin(diag, 6, 0);
        putWin(horiz, 7, 0);
        putWin(uniform9, X_MAX, Y_MAX);
        idle(4);
        check("frame2 count", 32'(frameEdgeCount), 32'(3));
        check("frame2 doneCount", 32'(frameDonesSeen), 32'(2));

        // Reset one cycle after a valid window discards it.
        putWin(vert, 50, 3);
        pixelDataValid = 1'b0;
        reset = 1'b1;
        @(negedge mainClk);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge mainClk);
            if (edgeValid) cnt++;
        end
        check("reset discard", 32'(cnt), 32'(0));
        check("reset frameEdgeCount", 32'(frameEdgeCount), 32'(0));
        putWin(vert, 60, 4);
        idle(1);
        check("post-reset early", 32'(edgeValid), 32'(0));
        idle(1);
        check("post-reset valid", 32'(edgeValid), 32'(1));
        check("post-reset mag", 32'(edgeMag), 32'(7));
        check("post-reset x", 32'(edgeX), 32'(60));
        idle(3);

        check("scoreboard drained", 32'(pending.size()), 32'(0));
        monitorOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
